// File: rtl/bus_drvr_fifo_if_pkg.sv
// Bus word field definitions shared by the driver buffers, the bus
// generator/arbiter and the 5-driver bus wrapper.
package bus_drvr_fifo_if_pkg;

    // Word width used on the parallel bus.
    localparam int BUS_BITS = 32;

    // The destination ID is held in the top byte of every bus word.
    localparam int DEST_MSB = BUS_BITS - 1;
    localparam int DEST_LSB = BUS_BITS - 8;

    // Destination that addresses every driver on the bus.
    localparam logic [7:0] BROADCAST_ID = 8'hFF;

    // Return the destination ID field of a bus word.
    function automatic logic [7:0] get_dest(input logic [BUS_BITS-1:0] word);
        return word[DEST_MSB:DEST_LSB];
    endfunction

endpackage

// File: rtl/bus_drvr_fifo_if_if.sv
// Handshake bundle between one driver port, its client and the bus arbiter.
// The slave modport is the buffering stage; the master modport is the
// environment (client plus arbiter) that drives it.
interface bus_drvr_fifo_if_if #(
    parameter int bits = 32
);
    // Client transmit side
    logic            tx_valid;
    logic            tx_ready;
    logic [bits-1:0] tx_data;
    // Arbiter side
    logic            pndng;
    logic            pop;
    logic [bits-1:0] D_pop;
    logic            push;
    logic [bits-1:0] D_push;
    // Client receive side
    logic            rx_valid;
    logic            rx_ready;
    logic [bits-1:0] rx_data;
    // Receive status
    logic            rx_ovf;
    logic [7:0]      rx_drop_cnt;
    logic            rx_misroute;

    modport slave (
        input  tx_valid, tx_data, pop, push, D_push, rx_ready,
        output tx_ready, pndng, D_pop, rx_valid, rx_data,
               rx_ovf, rx_drop_cnt, rx_misroute
    );

    modport master (
        output tx_valid, tx_data, pop, push, D_push, rx_ready,
        input  tx_ready, pndng, D_pop, rx_valid, rx_data,
               rx_ovf, rx_drop_cnt, rx_misroute
    );

endinterface

// File: rtl/bus_drvr_fifo_if_sync_fifo_fwft.sv
// First-word fall-through synchronous FIFO. A read request on an empty FIFO
// is ignored; a write to a full FIFO is accepted only when a read frees the
// slot in the same cycle. The head word reads as zero while empty.
module sync_fifo_fwft #(
    parameter int bits  = 32,
    parameter int depth = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    rd_en,
    input  logic [bits-1:0]         wr_data,
    output logic [bits-1:0]         rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(depth):0]  count
);

    localparam int AW = $clog2(depth);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(depth);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [bits-1:0] mem_r [depth];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;
    logic            do_rd_s;
    logic            do_wr_s;

    assign full    = (count_r == FULL_CNT);
    assign empty   = (count_r == {(AW + 1){1'b0}});
    assign count   = count_r;
    assign do_rd_s = rd_en & ~empty;
    assign do_wr_s = wr_en & (~full | do_rd_s);

    // Storage array; contents are don't-care after reset so it has none.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap modulo depth; occupancy holds on simultaneous read+write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW + 1){1'b0}};
        end else begin
            if (do_wr_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_rd_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Fall-through head word, forced to zero while the FIFO is empty.
    always_comb begin
        rd_data = {bits{1'b0}};
        if (empty) begin
            rd_data = {bits{1'b0}};
        end else begin
            rd_data = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/bus_drvr_fifo_if.sv
// Driver-side buffering stage: TX queue toward the arbiter, RX queue from
// the arbiter, with receive overflow counting and misroute detection.
module bus_drvr_fifo_if
    import bus_drvr_fifo_if_pkg::*;
#(
    parameter int         bits      = 32,
    parameter int         depth     = 16,
    parameter logic [7:0] id        = 8'd0,
    parameter logic [7:0] broadcast = 8'hFF
) (
    input logic               clk,
    input logic               reset,
    bus_drvr_fifo_if_if.slave bif
);

    localparam int CW = $clog2(depth) + 1;

    logic            tx_full_s;
    logic            tx_empty_s;
    logic [CW-1:0]   tx_count_s;
    logic            tx_wr_s;
    logic            rx_full_s;
    logic            rx_empty_s;
    logic [CW-1:0]   rx_count_s;
    logic            rx_rd_s;
    logic            rx_drop_s;
    logic            rx_store_s;
    logic            rx_misroute_s;
    logic [7:0]      dest_s;
    logic            rx_ovf_r;
    logic [7:0]      rx_drop_cnt_r;
    logic            rx_misroute_r;
    logic            unused_count_s;

    // A full TX queue refuses writes even when the arbiter pops in the same
    // cycle, so the client sees a ready that depends only on occupancy.
    assign tx_wr_s = bif.tx_valid & ~tx_full_s;

    sync_fifo_fwft #(
        .bits  (bits),
        .depth (depth)
    ) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (tx_wr_s),
        .rd_en   (bif.pop),
        .wr_data (bif.tx_data),
        .rd_data (bif.D_pop),
        .full    (tx_full_s),
        .empty   (tx_empty_s),
        .count   (tx_count_s)
    );

    // The RX queue may take a push while full if the client reads that cycle.
    sync_fifo_fwft #(
        .bits  (bits),
        .depth (depth)
    ) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bif.push),
        .rd_en   (bif.rx_ready),
        .wr_data (bif.D_push),
        .rd_data (bif.rx_data),
        .full    (rx_full_s),
        .empty   (rx_empty_s),
        .count   (rx_count_s)
    );

    assign bif.tx_ready    = ~tx_full_s;
    assign bif.pndng       = ~tx_empty_s;
    assign bif.rx_valid    = ~rx_empty_s;
    assign bif.rx_ovf      = rx_ovf_r;
    assign bif.rx_drop_cnt = rx_drop_cnt_r;
    assign bif.rx_misroute = rx_misroute_r;

    // Occupancy counts are only needed by the FIFOs' own flags here.
    assign unused_count_s = ^{tx_count_s, rx_count_s};

    // Classify each push: dropped (no room, no read) or stored, and whether a
    // stored word was addressed to someone else.
    always_comb begin
        rx_rd_s       = bif.rx_ready & ~rx_empty_s;
        dest_s        = get_dest(bif.D_push);
        rx_drop_s     = 1'b0;
        rx_store_s    = 1'b0;
        rx_misroute_s = 1'b0;
        if (bif.push) begin
            rx_drop_s  = rx_full_s & ~rx_rd_s;
            rx_store_s = ~rx_drop_s;
        end else begin
            rx_drop_s  = 1'b0;
            rx_store_s = 1'b0;
        end
        if (rx_store_s && (dest_s != id) && (dest_s != broadcast)) begin
            rx_misroute_s = 1'b1;
        end else begin
            rx_misroute_s = 1'b0;
        end
    end

    // Sticky receive status and saturating drop counter; cleared only by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_ovf_r      <= 1'b0;
            rx_drop_cnt_r <= 8'd0;
            rx_misroute_r <= 1'b0;
        end else begin
            if (rx_drop_s) begin
                rx_ovf_r <= 1'b1;
                if (rx_drop_cnt_r != 8'hFF) begin
                    rx_drop_cnt_r <= rx_drop_cnt_r + 8'd1;
                end
            end
            if (rx_misroute_s) begin
                rx_misroute_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_drvr_fifo_if.sv
// Directed bench for bus_drvr_fifo_if with id=2 and 16-entry FIFOs.
module tb_bus_drvr_fifo_if;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    bus_drvr_fifo_if_if #(.bits(32)) bif ();

    bus_drvr_fifo_if #(
        .bits      (32),
        .depth     (16),
        .id        (8'd2),
        .broadcast (8'hFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every vector, reports miscompares.
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between clock edges.
    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_tx_ready"},    {31'd0, bif.tx_ready},    32'd1);
        check_val({pfx, "_pndng"},       {31'd0, bif.pndng},       32'd0);
        check_val({pfx, "_D_pop"},       bif.D_pop,                32'd0);
        check_val({pfx, "_rx_valid"},    {31'd0, bif.rx_valid},    32'd0);
        check_val({pfx, "_rx_data"},     bif.rx_data,              32'd0);
        check_val({pfx, "_rx_ovf"},      {31'd0, bif.rx_ovf},      32'd0);
        check_val({pfx, "_rx_drop_cnt"}, {24'd0, bif.rx_drop_cnt}, 32'd0);
        check_val({pfx, "_rx_misroute"}, {31'd0, bif.rx_misroute}, 32'd0);
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b0;
        bif.tx_valid  = 1'b0;
        bif.tx_data   = 32'd0;
        bif.pop       = 1'b0;
        bif.push      = 1'b0;
        bif.D_push    = 32'd0;
        bif.rx_ready  = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b1;

        // Single TX word, visible one cycle after the write.
        bif.tx_valid = 1'b1;
        bif.tx_data  = 32'h0100_00AA;
        tick();
        bif.tx_valid = 1'b0;
        check_val("tx1_pndng", {31'd0, bif.pndng}, 32'd1);
        check_val("tx1_D_pop", bif.D_pop, 32'h0100_00AA);
        bif.pop = 1'b1;
        tick();
        bif.pop = 1'b0;
        check_val("tx1_pndng_after_pop", {31'd0, bif.pndng}, 32'd0);

        // Fill TX, then try a 17th word together with a pop.
        for (int i = 0; i < 16; i++) begin
            bif.tx_valid = 1'b1;
            bif.tx_data  = 32'h0200_1000 + i;
            tick();
        end
        bif.tx_valid = 1'b0;
        check_val("txf_ready_full", {31'd0, bif.tx_ready}, 32'd0);
        check_val("txf_head0", bif.D_pop, 32'h0200_1000);
        bif.tx_valid = 1'b1;
        bif.tx_data  = 32'hDEAD_BEEF;
        bif.pop      = 1'b1;
        tick();
        bif.tx_valid = 1'b0;
        bif.pop      = 1'b0;
        check_val("txf_ready_15", {31'd0, bif.tx_ready}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            check_val("txf_order", bif.D_pop, 32'h0200_1000 + i);
            bif.pop = 1'b1;
            tick();
            bif.pop = 1'b0;
        end
        check_val("txf_drained", {31'd0, bif.pndng}, 32'd0);
        check_val("txf_D_pop_zero", bif.D_pop, 32'd0);

        // RX overflow: 16 stored, 3 dropped.
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            bif.push   = 1'b1;
            bif.D_push = 32'h0200_0100 + i;
            tick();
        end
        check_val("rxo_ovf_before", {31'd0, bif.rx_ovf}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            bif.D_push = 32'h0200_0EEE;
            tick();
        end
        bif.push = 1'b0;
        check_val("rxo_ovf", {31'd0, bif.rx_ovf}, 32'd1);
        check_val("rxo_drop_cnt", {24'd0, bif.rx_drop_cnt}, 32'd3);
        check_val("rxo_misroute", {31'd0, bif.rx_misroute}, 32'd0);
        check_val("rxo_head0", bif.rx_data, 32'h0200_0100);

        // Full RX with a same-cycle read: the push reuses the freed slot.
        bif.push     = 1'b1;
        bif.D_push   = 32'h0000_0055;
        bif.rx_ready = 1'b1;
        tick();
        bif.push     = 1'b0;
        bif.rx_ready = 1'b0;
        check_val("rxs_drop_cnt", {24'd0, bif.rx_drop_cnt}, 32'd3);
        check_val("rxs_misroute", {31'd0, bif.rx_misroute}, 32'd1);
        for (int i = 1; i < 16; i++) begin
            check_val("rxs_order", bif.rx_data, 32'h0200_0100 + i);
            bif.rx_ready = 1'b1;
            tick();
            bif.rx_ready = 1'b0;
        end
        check_val("rxs_last", bif.rx_data, 32'h0000_0055);
        check_val("rxs_last_valid", {31'd0, bif.rx_valid}, 32'd1);
        bif.rx_ready = 1'b1;
        tick();
        bif.rx_ready = 1'b0;
        check_val("rxs_empty", {31'd0, bif.rx_valid}, 32'd0);

        // Misroute detection with id=2.
        pulse_reset();
        bif.push   = 1'b1;
        bif.D_push = 32'h0200_0001;
        tick();
        check_val("mr_own", {31'd0, bif.rx_misroute}, 32'd0);
        bif.D_push = 32'hFF00_0002;
        tick();
        check_val("mr_bcast", {31'd0, bif.rx_misroute}, 32'd0);
        bif.D_push = 32'h0300_0003;
        tick();
        bif.push = 1'b0;
        check_val("mr_other", {31'd0, bif.rx_misroute}, 32'd1);
        check_val("mr_rd0", bif.rx_data, 32'h0200_0001);
        bif.rx_ready = 1'b1;
        tick();
        check_val("mr_rd1", bif.rx_data, 32'hFF00_0002);
        tick();
        check_val("mr_rd2", bif.rx_data, 32'h0300_0003);
        tick();
        bif.rx_ready = 1'b0;
        check_val("mr_empty", {31'd0, bif.rx_valid}, 32'd0);

        // Asynchronous reset with both FIFOs half-full and 5 drops counted.
        pulse_reset();
        bif.push = 1'b1;
        for (int i = 0; i < 21; i++) begin
            bif.D_push = 32'h0200_2000 + i;
            tick();
        end
        bif.push     = 1'b0;
        bif.rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
        end
        bif.rx_ready = 1'b0;
        bif.tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bif.tx_data = 32'h0400_3000 + i;
            tick();
        end
        bif.tx_valid = 1'b0;
        check_val("ar_drop_cnt_pre", {24'd0, bif.rx_drop_cnt}, 32'd5);
        check_val("ar_rx_data_pre", bif.rx_data, 32'h0200_2008);
        check_val("ar_D_pop_pre", bif.D_pop, 32'h0400_3000);
        #2;
        reset = 1'b0;
        #1;
        check_reset_vals("ar");
        #2;
        reset = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bus_drvr_fifo_if.md
# bus_drvr_fifo_if

Driver-side buffering stage for the parallel bus generator/arbiter. One instance per driver port: it queues client words for transmission, exposes them to the arbiter through the pending/pop/data handshake, and captures words the arbiter pushes back to this driver. The bus side has no backpressure on push, so receive overflow is detected, counted and flagged. Five instances sit directly on the drvr_0..drvr_4 ports of the 5-driver bus wrapper.

## Interface
- bits, 32: word width; bits [bits-1:bits-8] hold the destination ID
- depth, 16: entries per FIFO, power of two, at least 2
- id, 0: this driver's 8-bit ID
- broadcast, 8'hFF: destination value addressing every driver
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- tx_valid  in  1  client offers tx_data
- tx_ready  out  1  TX FIFO not full
- tx_data  in  bits  client word
- pndng  out  1  TX FIFO not empty, to arbiter
- pop  in  1  arbiter consumes head word
- D_pop  out  bits  TX head word, valid while pndng=1
- push  in  1  arbiter delivers D_push
- D_push  in  bits  delivered word
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  client consumes rx_data
- rx_data  out  bits  RX head word
- rx_ovf  out  1  sticky: at least one pushed word dropped
- rx_drop_cnt  out  8  dropped-word count, saturates at 255
- rx_misroute  out  1  sticky: a word was stored whose dest is neither id nor broadcast

## Operation
- TX write when tx_valid & tx_ready. tx_ready = !tx_full only; a write to a full FIFO is not accepted even if pop is high in the same cycle.
- TX read when pop & pndng. pop while pndng=0 is ignored and leaves state unchanged.
- RX write when push and the RX FIFO has room, or when full and rx_valid & rx_ready in the same cycle (the freed slot is reused).
- push into a full RX FIFO with no simultaneous read: the word is dropped, rx_ovf is set, and rx_drop_cnt increments, holding at 255.
- RX read when rx_valid & rx_ready. rx_ready while empty is ignored.
- Simultaneous read and write on a non-empty, non-full FIFO: the occupancy count is unchanged and both pointers advance.
- Write on an empty FIFO with a read request in the same cycle: the read is ignored, and the word appears the next cycle.
- Each stored RX word is checked against id and broadcast. On a mismatch, rx_misroute is set and the word is still stored.
- Pointers are log2(depth) bits and wrap modulo depth. The count is log2(depth)+1 bits. full = (count == depth); empty = (count == 0).
- Sticky flags and the counter clear only on reset.

## Timing
- Reset values: tx_ready=1, pndng=0, D_pop=0, rx_valid=0, rx_data=0, rx_ovf=0, rx_drop_cnt=0, rx_misroute=0. FIFO contents are don't-care.
- Reset assertion mid-operation: pointers and counts clear asynchronously, and all queued words are discarded.
- FIFOs are first-word fall-through. D_pop and rx_data are combinational from the head entry.
- Write-to-visible latency is 1 cycle: a word written at edge N drives pndng/rx_valid=1 after edge N.
- Pop at edge N: the next word, or pndng=0, is presented after edge N.
- Throughput is one word per cycle per direction, sustained.
- Flags rx_ovf, rx_drop_cnt and rx_misroute update at the edge where the triggering push is sampled.

## Structure
- Shared package holds the bus word field constants (DEST_MSB, DEST_LSB, BROADCAST_ID) and a function extracting the dest field. These are shared with the bus generator/arbiter and the bus wrapper.
- Sub-module sync_fifo_fwft (bits, depth) provides push, pop, data in/out, full, empty and count. It is instantiated twice (TX and RX).
- The top level holds the handshake qualification, the overflow/misroute logic and the drop counter.

## Test plan
- Reset, then write tx_data 32'h01_00_00_AA with pop held low. Required: pndng=1 and D_pop=32'h010000AA one cycle later. Pop once: pndng=0.
- Fill TX with 16 words while pop=0. Required: tx_ready=0 after the 16th. A 17th attempt with pop=1 in the same cycle is not accepted. Output order is 0..15 with no loss.
- Fill RX with 16 pushes while rx_ready=0, then 3 more pushes. Required: rx_ovf=1, rx_drop_cnt=3, and the 16 original words are read back in order.
- RX full, push 32'h00_00_00_55 with rx_ready=1 in the same cycle. Required: no drop, and that word is read last with count still 16.
- With id=2, push 32'h02_00_00_01, 32'hFF_00_00_02 and 32'h03_00_00_03. Required: rx_misroute is set only after the third push, and all three words are stored.
- Assert reset while both FIFOs are half-full and rx_drop_cnt=5. Required: all outputs return to their reset values immediately, with no clock edge needed.
